// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types, helpers and detector test constants for the serial sequence generator
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0] SEQ_101  = 3'b101;
    localparam logic [3:0] SEQ_1011 = 4'b1011;

    // A length of zero, or one longer than the pattern register, means "send everything".
    function automatic int len_eff(input int len, input int width);
        return ((len == 0) || (len > width)) ? width : len;
    endfunction

endpackage

// File: rtl/seq_bit_tick.sv
// rtl/seq_bit_tick.sv - DIV-cycle down-counter with load/enable and terminal-count output
module seq_bit_tick #(
    parameter  int DIV = 1,
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tc
);

    logic [CW-1:0] cnt;

    // Count down while enabled and reload at terminal count; with DIV=1 the count never leaves 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load || (en && (cnt == '0))) begin
            cnt <= CW'(DIV - 1);
        end else if (en) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/serial_seq_gen.sv
// rtl/serial_seq_gen.sv - MSB-first serial pattern transmitter with one-shot and repeat modes
module serial_seq_gen
    import seq_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DIV   = 1,
    localparam int LW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LW-1:0]    len,
    input  logic             rpt,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

    state_t             state, state_n;
    logic [WIDTH-1:0]   sr, sr_n;
    logic [WIDTH-1:0]   sh_pat, sh_pat_n;
    logic [LW-1:0]      sh_len, sh_len_n;
    logic [LW-1:0]      bcnt, bcnt_n;
    logic               dout_n, dout_valid_n, busy_n, done_n;
    logic [LW-1:0]      le;
    logic [WIDTH-1:0]   ld;
    logic               tick_load, tick_en, tick_tc;

    seq_bit_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .load (tick_load),
        .en   (tick_en),
        .tc   (tick_tc)
    );

    // State, shift/shadow registers and all outputs are registered together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sr         <= '0;
            sh_pat     <= '0;
            sh_len     <= '0;
            bcnt       <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            sr         <= sr_n;
            sh_pat     <= sh_pat_n;
            sh_len     <= sh_len_n;
            bcnt       <= bcnt_n;
            dout       <= dout_n;
            dout_valid <= dout_valid_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

    // Next-state logic: the first bit goes out on the load edge, the rest are shifted from sr.
    always_comb begin
        state_n      = state;
        sr_n         = sr;
        sh_pat_n     = sh_pat;
        sh_len_n     = sh_len;
        bcnt_n       = bcnt;
        dout_n       = dout;
        dout_valid_n = dout_valid;
        busy_n       = busy;
        done_n       = 1'b0;
        tick_load    = 1'b0;
        tick_en      = 1'b0;
        ld           = '0;
        le           = LW'(len_eff(int'(len), WIDTH));

        case (state)
            IDLE: begin
                dout_n       = 1'b0;
                dout_valid_n = 1'b0;
                busy_n       = 1'b0;
                if (start) begin
                    sh_pat_n     = pattern;
                    sh_len_n     = le;
                    ld           = pattern << (LW'(WIDTH) - le);
                    dout_n       = ld[WIDTH-1];
                    sr_n         = ld << 1;
                    bcnt_n       = le - LW'(1);
                    dout_valid_n = 1'b1;
                    busy_n       = 1'b1;
                    tick_load    = 1'b1;
                    state_n      = SHIFT;
                end
            end
            SHIFT: begin
                tick_en = 1'b1;
                if (tick_tc) begin
                    if (bcnt != '0) begin
                        dout_n = sr[WIDTH-1];
                        sr_n   = sr << 1;
                        bcnt_n = bcnt - LW'(1);
                    end else if (rpt) begin
                        // Replay from the shadow copy so live pattern/len edits cannot leak in.
                        ld     = sh_pat << (LW'(WIDTH) - sh_len);
                        dout_n = ld[WIDTH-1];
                        sr_n   = ld << 1;
                        bcnt_n = sh_len - LW'(1);
                    end else begin
                        dout_n       = 1'b0;
                        dout_valid_n = 1'b0;
                        busy_n       = 1'b0;
                        done_n       = 1'b1;
                        state_n      = DONE;
                    end
                end
            end
            DONE: begin
                dout_n       = 1'b0;
                dout_valid_n = 1'b0;
                busy_n       = 1'b0;
                state_n      = IDLE;
            end
            default: begin
                sr_n         = '0;
                bcnt_n       = '0;
                dout_n       = 1'b0;
                dout_valid_n = 1'b0;
                busy_n       = 1'b0;
                state_n      = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_seq_gen.sv
// tb/tb_serial_seq_gen.sv - self-checking bench for serial_seq_gen at DIV=1 and DIV=4
module tb_serial_seq_gen;
    import seq_pkg::*;

    localparam int DIV_F = 1;
    localparam int DIV_S = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start = 1'b0;
    logic [7:0] pattern = 8'h00;
    logic [3:0] len = 4'd0;
    logic       rpt = 1'b0;
    logic       dout_f, val_f, busy_f, done_f;
    logic       dout_s, val_s, busy_s, done_s;

    int vectors = 0;
    int fails = 0;

    serial_seq_gen #(.WIDTH(8), .DIV(DIV_F)) u_fast (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len), .rpt(rpt),
        .dout(dout_f), .dout_valid(val_f), .busy(busy_f), .done(done_f)
    );

    serial_seq_gen #(.WIDTH(8), .DIV(DIV_S)) u_slow (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len), .rpt(rpt),
        .dout(dout_s), .dout_valid(val_s), .busy(busy_s), .done(done_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int leff(input int l);
        return ((l == 0) || (l > 8)) ? 8 : l;
    endfunction

    function automatic int dv(input int i);
        return (i == 0) ? DIV_F : DIV_S;
    endfunction

    // Model: phase 0 idle, 1 sending (k = cycles into the pass), 2 done pulse.
    int         phase[2] = '{0, 0};
    int         k[2]     = '{0, 0};
    int         mlen[2]  = '{8, 8};
    logic [7:0] mpat[2]  = '{8'h00, 8'h00};

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                phase[i] <= 0;
                k[i]     <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                case (phase[i])
                    0: if (start) begin
                        mpat[i]  <= pattern;
                        mlen[i]  <= leff(int'(len));
                        k[i]     <= 0;
                        phase[i] <= 1;
                    end
                    1: if (k[i] == mlen[i] * dv(i) - 1) begin
                        if (rpt) k[i] <= 0;
                        else     phase[i] <= 2;
                    end else begin
                        k[i] <= k[i] + 1;
                    end
                    default: phase[i] <= 0;
                endcase
            end
        end
    end

    // Expected {dout, dout_valid, busy, done}.
    function automatic logic [3:0] exp_of(input int i);
        logic b;
        if (phase[i] == 1) begin
            b = mpat[i][mlen[i] - 1 - k[i] / dv(i)];
            return {b, 3'b110};
        end else if (phase[i] == 2) begin
            return 4'b0001;
        end
        return 4'b0000;
    endfunction

    always @(negedge clk) begin
        check("out_fast", {28'd0, dout_f, val_f, busy_f, done_f}, {28'd0, exp_of(0)});
        check("out_slow", {28'd0, dout_s, val_s, busy_s, done_s}, {28'd0, exp_of(1)});
    end

    // Downstream 101 detector on the fast line; history clears whenever the line is not valid.
    logic [1:0] hist = 2'b00;
    int         flags = 0;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist <= 2'b00;
        end else if (val_f) begin
            hist <= {hist[0], dout_f};
            if ({hist, dout_f} == SEQ_101) flags <= flags + 1;
        end else begin
            hist <= 2'b00;
        end
    end

    logic [31:0] cap;

    task automatic pulse_start(input logic [7:0] p, input logic [3:0] l, input logic r);
        @(negedge clk);
        start = 1'b1; pattern = p; len = l; rpt = r;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic cap_bits(input int n);
        for (int j = 0; j < n; j++) begin
            cap = {cap[30:0], dout_f};
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (!busy_f && !busy_s && !done_f && !done_s) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_timeout", {31'd0, ok}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int fl0, vc, dc;
        logic [2:0] sb;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outs", {28'd0, dout_f, val_f, busy_f, done_f, dout_s, val_s, busy_s, done_s}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Basic pass: 101, done on cycle 4, idle on cycle 5, one detector hit.
        fl0 = flags;
        pulse_start(8'h05, 4'd3, 1'b0);
        cap = 0; cap_bits(3);
        check("basic_bits", cap, 32'b101);
        check("basic_done", {31'd0, done_f}, 32'd1);
        @(negedge clk);
        check("basic_idle", {30'd0, busy_f, done_f}, 32'd0);
        check("basic_flags", flags - fl0, 32'd1);
        wait_idle();

        // Full width via len=0, then via len>WIDTH.
        pulse_start(8'hB4, 4'd0, 1'b0);
        cap = 0; cap_bits(8);
        check("full_bits", cap, 32'hB4);
        check("full_done", {31'd0, done_f}, 32'd1);
        wait_idle();
        pulse_start(8'hA5, 4'd12, 1'b0);
        cap = 0; cap_bits(8);
        check("over_bits", cap, 32'hA5);
        wait_idle();

        // Slow bit period on the DIV=4 instance.
        pulse_start(8'h05, 4'd3, 1'b0);
        vc = 0; dc = 0; sb = 3'b000;
        for (int c = 1; c <= 14; c++) begin
            if (val_s) vc++;
            if (done_s) dc = c;
            if ((c % 4 == 1) && (c <= 9)) sb = {sb[1:0], dout_s};
            @(negedge clk);
        end
        check("slow_valid_cycles", vc, 32'd12);
        check("slow_done_cycle", dc, 32'd13);
        check("slow_bits", {29'd0, sb}, 32'b101);
        wait_idle();

        // Repeat: three passes, drop rpt in the fourth, which then completes.
        fl0 = flags;
        pulse_start(8'h05, 4'd3, 1'b1);
        cap = 0; cap_bits(9);
        check("rpt_bits", cap, 32'b101101101);
        rpt = 1'b0;
        cap = 0; cap_bits(3);
        check("rpt_last_bits", cap, 32'b101);
        check("rpt_done", {31'd0, done_f}, 32'd1);
        check("rpt_flags", flags - fl0, 32'd4);
        wait_idle();

        // Start and pattern change during busy are ignored.
        pulse_start(8'hB4, 4'd0, 1'b0);
        cap = 0; cap_bits(2);
        start = 1'b1; pattern = 8'hFF; len = 4'd3;
        cap_bits(1);
        start = 1'b0;
        cap_bits(5);
        check("busy_start_bits", cap, 32'hB4);
        check("busy_start_done", {31'd0, done_f}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("busy_start_no_restart", {30'd0, busy_f, val_f}, 32'd0);
        wait_idle();

        // Reset during bit 2, then a clean transfer.
        pulse_start(8'h05, 4'd3, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check("async_reset", {28'd0, dout_f, val_f, busy_f, done_f, dout_s, val_s, busy_s, done_s}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_no_done", {31'd0, done_f}, 32'd0);
        pulse_start(8'h05, 4'd3, 1'b0);
        cap = 0; cap_bits(3);
        check("post_reset_bits", cap, 32'b101);
        check("post_reset_done", {31'd0, done_f}, 32'd1);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
